vm_coin_feeder: RTL and testbench
=================================

Name: vm_coin_feeder

Overview:
- Customer-side initiator for the vending machine coin bus. It drives 2-bit coin codes into the machine's coin input and decodes the machine's item and change outputs.
- Given an item request and a wallet of 5 rs and 10 rs coins, it plans a coin sequence, feeds one coin per cycle with no gaps, waits for the dispense/change response and reports the result.
- Used as the bench/host-side driver and as the front end of the kiosk payment path.

Parameters:
- TIMEOUT, 4, cycles to wait for a non-zero machine response after the last coin (or abort gap) before flagging MISMATCH.
- WW, 3, width of the wallet coin-count inputs and used-count outputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- item_sel  in  1  0 = standard item (vm out 01), 1 = special item (vm out 10).
- n5  in  WW  available 5 rs coins; sampled with start.
- n10  in  WW  available 10 rs coins; sampled with start.
- abort  in  1  customer cancel; effective only in FEED.
- coin  out  2  to machine coin input: 00 none, 01 = 5 rs, 10 = 10 rs; 11 never driven.
- vm_out  in  2  machine item output.
- vm_change  in  2  machine change output.
- busy  out  1  high from PLAN through DONE.
- done  out  1  one-cycle result pulse.
- status  out  2  valid with done: 00 OK, 01 NO_FUNDS, 10 MISMATCH, 11 REFUNDED.
- got_item  out  2  captured vm_out; held until next start.
- got_change  out  2  captured vm_change; held until next start.
- used5  out  WW  5 rs coins fed this transaction.
- used10  out  WW  10 rs coins fed this transaction.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - coin, busy, done, status, got_item, got_change, used5 and used10 all reset to 0.
  - Reset mid-FEED drops coin to 00 immediately.
- All outputs are registered.
- Item price is 15 rs. Sequence plan, evaluated in PLAN, first match wins:
  - sel=1, n5>=1 and n10>=1: 01,10; expect item 10, change 00.
  - sel=0, n10>=1 and n5>=1: 10,01; expect item 01, change 00.
  - sel=0, n5>=3: 01,01,01; expect item 01, change 00.
  - sel=0, n10>=2: 10,10; expect item 01, change 01.
  - Otherwise: status NO_FUNDS; go to DONE with no coins driven.
- States and transitions:
  - IDLE: on start, capture item_sel, n5 and n10; clear got_*, used*; go to PLAN.
  - PLAN (1 cycle): select the sequence and length L (2 or 3); go to FEED.
  - FEED: drive one coin per cycle on cycles 1..L after PLAN, back-to-back. A gap would make the machine refund.
    - Increment used5 or used10 on each coin.
    - After the last coin, coin=00 and go to WAIT.
  - WAIT: count cycles from the first cycle after the final coin. The machine registers its response one cycle after the coin, so the response appears in WAIT cycle 1.
    - First cycle with vm_out!=00 or vm_change!=00: capture both into got_*.
    - status = OK if both match the expectation, else MISMATCH. Go to DONE.
    - No non-zero response within TIMEOUT cycles: status MISMATCH, got_* = 00.
  - DONE: done=1 for one cycle with status valid; busy drops with done; return to IDLE.
- Abort:
  - abort=1 in a FEED cycle before the final coin is driven: that slot drives 00 instead of a coin and no further coins are fed. Go to WAIT expecting item 00 and change equal to the inserted value (01 for 5 rs, 10 for 10 rs).
  - A matching refund gives status REFUNDED; anything else gives MISMATCH.
  - abort during the final coin slot or later is ignored.
  - abort outside FEED is ignored.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: start wins, abort ignored.
- Counts never exceed 3; WW≥2 is required.

Decomposition:
- Shared package vm_pkg holds:
  - coin codes COIN_NONE=00, COIN_5=01, COIN_10=10, COIN_BAD=11;
  - item codes ITEM_STD=01, ITEM_SPECIAL=10;
  - status enum;
  - price constant 15.
- One sub-module, vm_seq_planner: combinational plan of sequence, length and expected response from item_sel, n5 and n10. The FSM, feeding and checking live in vm_coin_feeder.

Test Plan:
- sel=1, n5=2, n10=1, start → coin 01 then 10 on consecutive cycles; machine out=10 next cycle; done, status=00, got_item=10, used5=1, used10=1.
- sel=0, n5=3, n10=0 → coins 01,01,01; got_item=01, got_change=00, status=00, used5=3.
- sel=0, n5=0, n10=2 → coins 10,10; got_item=01, got_change=01, status=00.
- sel=1, n5=0, n10=3 → no coin driven; done 2 cycles after start with status=01.
- sel=0, n5=1, n10=1, abort during the second slot → coin 10 then 00; machine change=10; status=11, used10=1, used5=0.
- Machine model forced silent, or rst_n asserted mid-FEED → status=10 after TIMEOUT=4 WAIT cycles; on reset, coin=00 immediately and all outputs are zero.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared coin-bus codes, result status and purchase plan type for the vending machine feeder.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] ITEM_NONE    = 2'b00;
    localparam logic [1:0] ITEM_STD     = 2'b01;
    localparam logic [1:0] ITEM_SPECIAL = 2'b10;

    localparam int unsigned PRICE = 15;

    typedef enum logic [1:0] {
        StatOk       = 2'b00,
        StatNoFunds  = 2'b01,
        StatMismatch = 2'b10,
        StatRefunded = 2'b11
    } status_e;

    typedef struct packed {
        logic            ok;
        logic [1:0]      len;
        logic [2:0][1:0] seq;  // seq[0] is fed first
        logic [1:0]      exp_item;
        logic [1:0]      exp_change;
    } plan_t;

    // Change codes share the coin encoding: a single 5 rs or 10 rs coin back.
    function automatic logic [1:0] refund_code(int unsigned value);
        case (value)
            0:       return COIN_NONE;
            5:       return COIN_5;
            10:      return COIN_10;
            default: return COIN_BAD;
        endcase
    endfunction

endpackage

// File: rtl/vm_seq_planner.sv
// Combinational coin-sequence planner: picks the first affordable sequence for the request.
module vm_seq_planner
    import vm_pkg::*;
#(
    parameter int unsigned WW = 3
) (
    input  logic          item_sel,
    input  logic [WW-1:0] n5,
    input  logic [WW-1:0] n10,
    output plan_t         plan
);

    logic have5, have10;

    assign have5  = (n5 != '0);
    assign have10 = (n10 != '0);

    always_comb begin
        plan = '0;
        if (item_sel && have5 && have10) begin
            plan.ok       = 1'b1;
            plan.len      = 2'd2;
            plan.seq[0]   = COIN_5;
            plan.seq[1]   = COIN_10;
            plan.exp_item = ITEM_SPECIAL;
        end else if (!item_sel && have10 && have5) begin
            plan.ok       = 1'b1;
            plan.len      = 2'd2;
            plan.seq[0]   = COIN_10;
            plan.seq[1]   = COIN_5;
            plan.exp_item = ITEM_STD;
        end else if (!item_sel && n5 >= WW'(3)) begin
            plan.ok       = 1'b1;
            plan.len      = 2'd3;
            plan.seq[0]   = COIN_5;
            plan.seq[1]   = COIN_5;
            plan.seq[2]   = COIN_5;
            plan.exp_item = ITEM_STD;
        end else if (!item_sel && n10 >= WW'(2)) begin
            plan.ok         = 1'b1;
            plan.len        = 2'd2;
            plan.seq[0]     = COIN_10;
            plan.seq[1]     = COIN_10;
            plan.exp_item   = ITEM_STD;
            plan.exp_change = refund_code(20 - PRICE);
        end
    end

endmodule

// File: rtl/vm_coin_feeder.sv
// Customer-side coin bus initiator: plans, feeds coins back-to-back and checks the machine reply.
module vm_coin_feeder
    import vm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned WW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          item_sel,
    input  logic [WW-1:0] n5,
    input  logic [WW-1:0] n10,
    input  logic          abort,
    output logic [1:0]    coin,
    input  logic [1:0]    vm_out,
    input  logic [1:0]    vm_change,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [1:0]    got_item,
    output logic [1:0]    got_change,
    output logic [WW-1:0] used5,
    output logic [WW-1:0] used10
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StPlan, StFeed, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic [WW-1:0]   n5_q, n5_d, n10_q, n10_d;
    logic [2:0][1:0] seq_q, seq_d;
    logic [1:0]      len_q, len_d, idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      exp_item_q, exp_item_d, exp_chg_q, exp_chg_d;
    logic            aborted_q, aborted_d;
    logic [1:0]      coin_q, coin_d;
    logic            busy_q, busy_d, done_q, done_d;
    status_e         status_q, status_d;
    logic [1:0]      got_item_q, got_item_d, got_change_q, got_change_d;
    logic [WW-1:0]   used5_q, used5_d, used10_q, used10_d;

    plan_t       plan;
    logic        feed_en;
    logic [1:0]  feed_coin;
    int unsigned paid;
    logic        resp_seen, resp_ok;

    vm_seq_planner #(
        .WW(WW)
    ) u_planner (
        .item_sel(sel_q),
        .n5      (n5_q),
        .n10     (n10_q),
        .plan    (plan)
    );

    assign paid      = 32'd5 * 32'(used5_q) + 32'd10 * 32'(used10_q);
    assign resp_seen = (vm_out != 2'b00) || (vm_change != 2'b00);
    assign resp_ok   = (vm_out == exp_item_q) && (vm_change == exp_chg_q);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        n5_d         = n5_q;
        n10_d        = n10_q;
        seq_d        = seq_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        exp_item_d   = exp_item_q;
        exp_chg_d    = exp_chg_q;
        aborted_d    = aborted_q;
        status_d     = status_q;
        got_item_d   = got_item_q;
        got_change_d = got_change_q;
        used5_d      = used5_q;
        used10_d     = used10_q;
        coin_d       = COIN_NONE;
        feed_en      = 1'b0;
        feed_coin    = COIN_NONE;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sel_d        = item_sel;
                    n5_d         = n5;
                    n10_d        = n10;
                    got_item_d   = 2'b00;
                    got_change_d = 2'b00;
                    used5_d      = '0;
                    used10_d     = '0;
                    aborted_d    = 1'b0;
                    state_d      = StPlan;
                end
            end
            StPlan: begin
                if (plan.ok) begin
                    seq_d      = plan.seq;
                    len_d      = plan.len;
                    exp_item_d = plan.exp_item;
                    exp_chg_d  = plan.exp_change;
                    idx_d      = 2'd1;
                    feed_en    = 1'b1;
                    feed_coin  = plan.seq[0];
                    state_d    = StFeed;
                end else begin
                    status_d = StatNoFunds;
                    state_d  = StDone;
                end
            end
            StFeed: begin
                // Abort only matters while a coin slot is still pending.
                if (idx_q == len_q) begin
                    cnt_d   = CW'(1);
                    state_d = StWait;
                end else if (abort) begin
                    aborted_d  = 1'b1;
                    exp_item_d = ITEM_NONE;
                    exp_chg_d  = refund_code(paid);
                    cnt_d      = CW'(1);
                    state_d    = StWait;
                end else begin
                    feed_en   = 1'b1;
                    feed_coin = seq_q[idx_q];
                    idx_d     = idx_q + 2'd1;
                end
            end
            StWait: begin
                if (resp_seen) begin
                    got_item_d   = vm_out;
                    got_change_d = vm_change;
                    if (!resp_ok)       status_d = StatMismatch;
                    else if (aborted_q) status_d = StatRefunded;
                    else                status_d = StatOk;
                    state_d = StDone;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    status_d = StatMismatch;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (feed_en) begin
            coin_d = feed_coin;
            if (feed_coin == COIN_5)       used5_d  = used5_q + WW'(1);
            else if (feed_coin == COIN_10) used10_d = used10_q + WW'(1);
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            n5_q         <= '0;
            n10_q        <= '0;
            seq_q        <= '0;
            len_q        <= 2'd0;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            exp_item_q   <= 2'b00;
            exp_chg_q    <= 2'b00;
            aborted_q    <= 1'b0;
            coin_q       <= COIN_NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= StatOk;
            got_item_q   <= 2'b00;
            got_change_q <= 2'b00;
            used5_q      <= '0;
            used10_q     <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            n5_q         <= n5_d;
            n10_q        <= n10_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            exp_item_q   <= exp_item_d;
            exp_chg_q    <= exp_chg_d;
            aborted_q    <= aborted_d;
            coin_q       <= coin_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            status_q     <= status_d;
            got_item_q   <= got_item_d;
            got_change_q <= got_change_d;
            used5_q      <= used5_d;
            used10_q     <= used10_d;
        end
    end

    assign coin       = coin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign got_item   = got_item_q;
    assign got_change = got_change_q;
    assign used5      = used5_q;
    assign used10     = used10_q;

endmodule

// File: tb/tb_vm_coin_feeder.sv
// Bench for vm_coin_feeder: a behavioural vending machine on the coin bus plus a result scoreboard.
module tb_vm_coin_feeder;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned WW      = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          item_sel = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] n5 = '0;
    logic [WW-1:0] n10 = '0;
    logic [1:0]    coin, vm_out, vm_change, status, got_item, got_change;
    logic          busy, done;
    logic [WW-1:0] used5, used10;

    always #5 clk = ~clk;

    vm_coin_feeder #(
        .TIMEOUT(TIMEOUT),
        .WW     (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .item_sel  (item_sel),
        .n5        (n5),
        .n10       (n10),
        .abort     (abort),
        .coin      (coin),
        .vm_out    (vm_out),
        .vm_change (vm_change),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .got_item  (got_item),
        .got_change(got_change),
        .used5     (used5),
        .used10    (used10)
    );

    // Machine model: sums credit, vends at 15 rs, refunds on a gap in the coin stream.
    logic [1:0] mach_item = 2'b01;
    logic       mach_silent = 1'b0;
    int         credit;
    int         sum;

    function automatic logic [1:0] chg_code(int v);
        case (v)
            0:       return 2'b00;
            5:       return 2'b01;
            10:      return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit    <= 0;
            vm_out    <= 2'b00;
            vm_change <= 2'b00;
        end else begin
            vm_out    <= 2'b00;
            vm_change <= 2'b00;
            if (coin == 2'b01 || coin == 2'b10) begin
                sum = credit + ((coin == 2'b01) ? 5 : 10);
                if (sum >= 15) begin
                    credit <= 0;
                    if (!mach_silent) begin
                        vm_out    <= mach_item;
                        vm_change <= chg_code(sum - 15);
                    end
                end else begin
                    credit <= sum;
                end
            end else if (credit != 0) begin
                credit <= 0;
                if (!mach_silent) vm_change <= chg_code(credit);
            end
        end
    end

    typedef struct {
        int sel, n5, n10, mitem, silent, abort_at, restart_at, abort_ws;
        int st, it, ch, u5, u10, trace, lat;
    } txn_t;

    typedef struct {
        int st, it, ch, u5, u10, trace, lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_run = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(int sel, int a5, int a10, int mitem, int silent, int abort_at,
                                int restart_at, int abort_ws, int st, int it, int ch, int u5,
                                int u10, int trace, int lat);
        txn_t t;
        t.sel = sel; t.n5 = a5; t.n10 = a10; t.mitem = mitem; t.silent = silent;
        t.abort_at = abort_at; t.restart_at = restart_at; t.abort_ws = abort_ws;
        t.st = st; t.it = it; t.ch = ch; t.u5 = u5; t.u10 = u10; t.trace = trace; t.lat = lat;
        return t;
    endfunction

    task automatic run_txn(input txn_t t, input int id);
        exp_t       e;
        exp_t       r;
        logic [5:0] trace;
        int         bad;
        bit         got;
        int         m;
        mach_item   = 2'(t.mitem);
        mach_silent = t.silent[0];
        @(negedge clk);
        start    = 1'b1;
        item_sel = t.sel[0];
        n5       = WW'(t.n5);
        n10      = WW'(t.n10);
        abort    = t.abort_ws[0];
        e.st = t.st; e.it = t.it; e.ch = t.ch; e.u5 = t.u5; e.u10 = t.u10;
        e.trace = t.trace; e.lat = t.lat;
        exp_q.push_back(e);
        trace = '0;
        bad   = 0;
        got   = 1'b0;
        m     = 0;
        while (!got && m < 24) begin
            @(negedge clk);
            if (coin == 2'b11) bad++;
            if (coin != 2'b00) trace = {trace[3:0], coin};
            if (done) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    check($sformatf("t%0d_sb_empty", id), 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check($sformatf("t%0d_status", id), status, r.st);
                    check($sformatf("t%0d_item", id), got_item, r.it);
                    check($sformatf("t%0d_change", id), got_change, r.ch);
                    check($sformatf("t%0d_used5", id), used5, r.u5);
                    check($sformatf("t%0d_used10", id), used10, r.u10);
                    check($sformatf("t%0d_coins", id), trace, r.trace);
                    check($sformatf("t%0d_latency", id), m, r.lat);
                    check($sformatf("t%0d_coin11", id), bad, 0);
                    check($sformatf("t%0d_busy_at_done", id), busy, 1);
                end
            end
            start    = (m + 1 == t.restart_at);
            abort    = (m + 1 == t.abort_at);
            item_sel = 1'b0;
            n5       = '0;
            n10      = '0;
            m++;
        end
        start = 1'b0;
        abort = 1'b0;
        check($sformatf("t%0d_done_seen", id), got, 1);
        @(negedge clk);
        check($sformatf("t%0d_done_pulse", id), done, 0);
        check($sformatf("t%0d_busy_after", id), busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_coin"}, coin, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_status"}, status, 0);
        check({pfx, "_got_item"}, got_item, 0);
        check({pfx, "_got_change"}, got_change, 0);
        check({pfx, "_used5"}, used5, 0);
        check({pfx, "_used10"}, used10, 0);
    endtask

    txn_t tbl[15];

    initial begin
        // sel n5 n10 | mitem silent abort_at restart_at abort_ws | st item chg u5 u10 trace lat
        tbl[0]  = mk(1, 2, 1, 2, 0, 0, 0, 0, 0, 2, 0, 1, 1, 6'b000110, 4);
        tbl[1]  = mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 6'b010101, 5);
        tbl[2]  = mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2, 6'b001010, 4);
        tbl[3]  = mk(1, 0, 3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 1);
        tbl[4]  = mk(0, 1, 1, 1, 0, 2, 0, 0, 3, 0, 2, 0, 1, 6'b000010, 4);
        tbl[5]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 2, 0, 0, 1, 1, 6'b001001, 7);
        tbl[6]  = mk(0, 3, 0, 1, 0, 3, 0, 0, 3, 0, 2, 2, 0, 6'b000101, 5);
        tbl[7]  = mk(1, 1, 1, 2, 0, 3, 0, 0, 0, 2, 0, 1, 1, 6'b000110, 4);
        tbl[8]  = mk(0, 2, 1, 2, 0, 0, 0, 0, 2, 2, 0, 1, 1, 6'b001001, 4);
        tbl[9]  = mk(1, 1, 1, 2, 0, 0, 2, 0, 0, 2, 0, 1, 1, 6'b000110, 4);
        tbl[10] = mk(0, 0, 2, 1, 0, 0, 0, 1, 0, 1, 1, 0, 2, 6'b001010, 4);
        tbl[11] = mk(1, 3, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 1);
        tbl[12] = mk(0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 1);
        tbl[13] = mk(0, 3, 2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 6'b001001, 4);
        tbl[14] = mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 6'b001001, 4);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 15; i++) run_txn(tbl[i], i);

        // Reset while a coin is on the bus.
        mach_item   = 2'b10;
        mach_silent = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        item_sel = 1'b1;
        n5       = WW'(1);
        n10      = WW'(1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_pre_coin", coin, 1);
        check("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midfeed_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_coin", coin, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
